dmem_arbiter: RTL

Sequencing arbiter that shares the single-port data-memory BRAM between the CPU load/store path and the UART program loader. The MemOrIO decoder routes CPU accesses to memory or IO. This block runs every memory-space access as a request/grant/acknowledge transaction against a BRAM with 1-cycle read latency, and stalls the CPU while its access is pending. Accesses in the IO window 0xFFFF_FC00–0xFFFF_FFFF, such as LED at 0xFFFF_FC60 and switches at 0xFFFF_FC70, never reach this block's RAM port.

---
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory BRAM arbiter: CPU load/store path vs. UART program loader.
// Each access runs IDLE -> ACC -> DONE against a 1-cycle-latency BRAM.
module dmem_arbiter #(
  parameter int ADDR_W = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_mread,
  input  logic              cpu_mwrite,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              upg_en,
  input  logic              upg_req,
  input  logic [ADDR_W-1:0] upg_addr,
  input  logic [31:0]       upg_wdata,
  output logic              upg_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    CPU_ACC,
    CPU_DONE,
    UPG_ACC,
    UPG_DONE
  } state_t;

  state_t      state;
  logic        last_upg;
  logic        lat_we;
  logic [31:0] rdata_q;

  logic cpu_io;
  logic cpu_req;
  logic grant_cpu;
  logic grant_upg;
  logic unused_addr;

  assign unused_addr = ^cpu_addr[1:0];

  // Top 1 KiB of the address space belongs to the IO decoder.
  assign cpu_io    = &cpu_addr[31:10];
  assign cpu_req   = (cpu_mread | cpu_mwrite) & ~cpu_io & ~upg_en;
  assign grant_cpu = cpu_req & (~upg_req | last_upg);
  assign grant_upg = upg_req & ~grant_cpu;

  assign cpu_stall = cpu_req & ~cpu_ack;
  assign cpu_rdata = (state == CPU_DONE && !lat_we) ? ram_rdata : rdata_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last_upg  <= 1'b1;
      lat_we    <= 1'b0;
      rdata_q   <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cpu_ack   <= 1'b0;
      upg_ack   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            grant_cpu: begin
              state     <= CPU_ACC;
              last_upg  <= 1'b0;
              lat_we    <= cpu_mwrite;
              ram_en    <= 1'b1;
              ram_we    <= cpu_mwrite;
              ram_addr  <= cpu_addr[ADDR_W+1:2];
              ram_wdata <= cpu_wdata;
            end
            grant_upg: begin
              state     <= UPG_ACC;
              last_upg  <= 1'b1;
              lat_we    <= 1'b1;
              ram_en    <= 1'b1;
              ram_we    <= 1'b1;
              ram_addr  <= upg_addr;
              ram_wdata <= upg_wdata;
            end
            default: state <= IDLE;
          endcase
        end
        CPU_ACC: begin
          state     <= CPU_DONE;
          ram_en    <= 1'b0;
          ram_we    <= 1'b0;
          ram_addr  <= '0;
          ram_wdata <= '0;
          cpu_ack   <= 1'b1;
        end
        CPU_DONE: begin
          state   <= IDLE;
          cpu_ack <= 1'b0;
          if (!lat_we) rdata_q <= ram_rdata;
        end
        UPG_ACC: begin
          state     <= UPG_DONE;
          ram_en    <= 1'b0;
          ram_we    <= 1'b0;
          ram_addr  <= '0;
          ram_wdata <= '0;
          upg_ack   <= 1'b1;
        end
        UPG_DONE: begin
          state   <= IDLE;
          upg_ack <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
